selector_modo: RTL and testbench

- Parametrised mode controller for the digital clock. Replaces the fixed 2-bit-to-LED mode encoder.
- Takes a raw mode push-button, synchronises and debounces it, and steps through NUM_MODOS modes with wrap-around.
- Returns to mode 0 after an inactivity timeout.
- Drives the current mode code and a one-hot mode LED vector to the clock's display and time-setting logic.

---
 rtl/selector_modo.sv | 195 +++++++++++++++++++
 tb/tb_selector_modo.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/selector_modo.sv
// selector_modo: mode controller for the digital clock.
// Synchronises and debounces the mode push-button, steps through NUM_MODOS
// modes with wrap-around and falls back to mode 0 after TIMEOUT_CICLOS idle
// ticks. Optional macro LED_PARPADEO_EN makes the active mode LED blink in
// non-zero modes (ledsModo then becomes registered).
module selector_modo #(
  parameter int NUM_MODOS       = 3,
  parameter int MODO_W          = 2,
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int TIMEOUT_CICLOS  = 16,
  parameter int BLINK_CICLOS    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 btnModo,
  input  logic                 actividad,
  output logic [MODO_W-1:0]    modo,
  output logic [NUM_MODOS-1:0] ledsModo,
  output logic                 cambioModo
);

  localparam int DW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [MODO_W-1:0] MODO_MAX = MODO_W'(NUM_MODOS - 1);

  // Elaboration-time parameter legality checks.
  if (NUM_MODOS < 2 || NUM_MODOS > 2**MODO_W) begin : g_chk_modos
    $error("selector_modo: NUM_MODOS out of range");
  end
  if (DEBOUNCE_CICLOS < 1) begin : g_chk_debounce
    $error("selector_modo: DEBOUNCE_CICLOS must be >= 1");
  end
  if (TIMEOUT_CICLOS < 0) begin : g_chk_timeout
    $error("selector_modo: TIMEOUT_CICLOS must be >= 0");
  end
  if (BLINK_CICLOS < 1) begin : g_chk_blink
    $error("selector_modo: BLINK_CICLOS must be >= 1");
  end

  typedef enum logic [1:0] {
    ESTABLE_BAJO,
    VALIDANDO_ALTO,
    ESTABLE_ALTO,
    VALIDANDO_BAJO
  } estado_t;

  logic            btnMeta, btnSync;
  estado_t         estado;
  logic [DW-1:0]   cnt;
  logic            pulsacion;
  logic [TW-1:0]   tcnt;
  logic            expira;
  logic [NUM_MODOS-1:0] onehot;

  // Two-flop synchroniser for the asynchronous push-button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btnMeta <= 1'b0;
      btnSync <= 1'b0;
    end else begin
      btnMeta <= btnModo;
      btnSync <= btnMeta;
    end
  end

  // Debounce FSM: a new level must hold for DEBOUNCE_CICLOS ticks; press emits a pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado    <= ESTABLE_BAJO;
      cnt       <= '0;
      pulsacion <= 1'b0;
    end else begin
      pulsacion <= 1'b0;
      case (estado)
        ESTABLE_BAJO: begin
          if (btnSync) begin
            estado <= VALIDANDO_ALTO;
            cnt    <= '0;
          end
        end
        VALIDANDO_ALTO: begin
          if (!btnSync) begin
            estado <= ESTABLE_BAJO;
            cnt    <= '0;
          end else if (tick) begin
            if (cnt == DW'(DEBOUNCE_CICLOS - 1)) begin
              estado    <= ESTABLE_ALTO;
              cnt       <= '0;
              pulsacion <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ESTABLE_ALTO: begin
          if (!btnSync) begin
            estado <= VALIDANDO_BAJO;
            cnt    <= '0;
          end
        end
        VALIDANDO_BAJO: begin
          if (btnSync) begin
            estado <= ESTABLE_ALTO;
            cnt    <= '0;
          end else if (tick) begin
            if (cnt == DW'(DEBOUNCE_CICLOS - 1)) begin
              estado <= ESTABLE_BAJO;
              cnt    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          estado <= ESTABLE_BAJO;
          cnt    <= '0;
        end
      endcase
    end
  end

  // Timeout fires only when no press and no activity are present this edge.
  always_comb begin
    expira = (TIMEOUT_CICLOS != 0) && tick && !actividad && !pulsacion &&
             (modo != '0) && (tcnt == TW'(TIMEOUT_CICLOS - 1));
  end

  // Mode register and inactivity counter; a press takes priority over the timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      modo       <= '0;
      cambioModo <= 1'b0;
      tcnt       <= '0;
    end else begin
      cambioModo <= 1'b0;
      if (pulsacion) begin
        modo       <= (modo == MODO_MAX) ? '0 : modo + 1'b1;
        cambioModo <= 1'b1;
        tcnt       <= '0;
      end else if (actividad || modo == '0) begin
        tcnt <= '0;
      end else if (expira) begin
        modo       <= '0;
        cambioModo <= 1'b1;
        tcnt       <= '0;
      end else if (tick) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  // One-hot decode of the registered mode.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_MODOS; i++) begin
      if (modo == MODO_W'(i)) onehot[i] = 1'b1;
    end
  end

`ifdef LED_PARPADEO_EN
  localparam int BW = (BLINK_CICLOS > 1) ? $clog2(BLINK_CICLOS) : 1;

  logic          fase;
  logic [BW-1:0] bcnt;

  // Blink phase restarts "on" at every mode change; LEDs are registered from the old mode/phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fase     <= 1'b1;
      bcnt     <= '0;
      ledsModo <= NUM_MODOS'(1);
    end else begin
      ledsModo <= (modo == '0 || fase) ? onehot : '0;
      if (pulsacion || expira) begin
        fase <= 1'b1;
        bcnt <= '0;
      end else if (modo != '0 && tick) begin
        if (bcnt == BW'(BLINK_CICLOS - 1)) begin
          fase <= ~fase;
          bcnt <= '0;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end
`else
  // Steady indicator: active LED follows the registered mode directly.
  always_comb begin
    ledsModo = onehot;
  end
`endif

endmodule

// File: tb/tb_selector_modo.sv
// Testbench for selector_modo: behavioural model compared every cycle plus
// hand-computed literal checkpoints from directed stimulus.
module tb_selector_modo;
  localparam int N  = 3;
  localparam int MW = 2;
  localparam int D  = 4;
  localparam int T  = 16;
  localparam int B  = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick = 1'b1;
  logic          btnModo = 1'b0;
  logic          actividad = 1'b1;
  logic [MW-1:0] modo;
  logic [N-1:0]  ledsModo;
  logic          cambioModo;

  selector_modo #(
    .NUM_MODOS(N), .MODO_W(MW), .DEBOUNCE_CICLOS(D),
    .TIMEOUT_CICLOS(T), .BLINK_CICLOS(B)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .btnModo(btnModo),
    .actividad(actividad), .modo(modo), .ledsModo(ledsModo),
    .cambioModo(cambioModo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Button level is accepted after it differs from the stable level on one
  // edge and then for D further ticks; the accepted press steps the mode on
  // the following edge.
  int m_s1, m_s2, m_lvl, m_pend, m_press, m_modo, m_idle, m_cambio;
  int m_fase, m_bt, m_leds;
  int mb, mnew, mprev_modo, mprev_fase;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pend = -1; m_press = 0;
      m_modo = 0; m_idle = 0; m_cambio = 0; m_fase = 1; m_bt = 0; m_leds = 1;
    end else begin
      mb = m_s2; m_s2 = m_s1; m_s1 = int'(btnModo);
      mnew = 0;
      if (mb == m_lvl) m_pend = -1;
      else if (m_pend < 0) m_pend = 0;
      else if (tick) begin
        m_pend++;
        if (m_pend == D) begin m_lvl = mb; m_pend = -1; mnew = mb; end
      end
      mprev_modo = m_modo; mprev_fase = m_fase;
      m_cambio = 0;
      if (m_press != 0) begin
        m_modo = (m_modo + 1) % N; m_idle = 0; m_cambio = 1;
      end else if (actividad || m_modo == 0) begin
        m_idle = 0;
      end else if (tick) begin
        m_idle++;
        if (m_idle == T) begin m_modo = 0; m_idle = 0; m_cambio = 1; end
      end
      m_press = mnew;
      if (m_cambio != 0) begin
        m_fase = 1; m_bt = 0;
      end else if (mprev_modo != 0 && tick) begin
        m_bt++;
        if (m_bt == B) begin m_fase = 1 - m_fase; m_bt = 0; end
      end
`ifdef LED_PARPADEO_EN
      m_leds = (mprev_modo == 0 || mprev_fase != 0) ? (1 << mprev_modo) : 0;
`else
      m_leds = 1 << m_modo;
`endif
    end
  end

  // Compare process: every cycle outside reset.
  always @(posedge clk) begin
    #1;
    if (cmp_en && reset_n) begin
      check("model_modo", 32'(modo), 32'(m_modo));
      check("model_leds", 32'(ledsModo), 32'(m_leds));
      check("model_cambio", 32'(cambioModo), 32'(m_cambio));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean press: button sampled high at edge 0, mode changes at edge 7.
  task automatic press_to(input int exp);
    btnModo = 1'b1;
    step(7);
    check("press_before", 32'(cambioModo), 32'd0);
    step(1);
    check("press_modo", 32'(modo), 32'(exp));
    check("press_pulse", 32'(cambioModo), 32'd1);
    btnModo = 1'b0;
  endtask

  logic [4:0] bounce;

  initial begin
    // Reset
    #23;
    check("rst_modo", 32'(modo), 32'd0);
    check("rst_leds", 32'(ledsModo), 32'b001);
    check("rst_cambio", 32'(cambioModo), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cmp_en = 1'b1;
    step(3);

    // First press: latency D+3
    btnModo = 1'b1;
    step(7);
    check("lat_e6_modo", 32'(modo), 32'd0);
    step(1);
    check("lat_e7_modo", 32'(modo), 32'd1);
    check("lat_e7_cambio", 32'(cambioModo), 32'd1);
`ifndef LED_PARPADEO_EN
    check("lat_e7_leds", 32'(ledsModo), 32'b010);
`endif
    step(1);
    check("lat_e8_cambio", 32'(cambioModo), 32'd0);
    btnModo = 1'b0;
    step(12);
    check("release_no_step", 32'(modo), 32'd1);

    // Bounce 1,0,1,0,1 then held
    bounce = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      btnModo = bounce[i];
      step(1);
    end
    step(6);
    check("bounce_f6", 32'(modo), 32'd1);
    step(1);
    check("bounce_f7", 32'(modo), 32'd2);
    btnModo = 1'b0;
    step(12);

    // Wrap-around and three clean presses
    press_to(0); step(12);
    press_to(1);
`ifndef LED_PARPADEO_EN
    check("seq_leds1", 32'(ledsModo), 32'b010);
`endif
    step(12);
    press_to(2);
`ifndef LED_PARPADEO_EN
    check("seq_leds2", 32'(ledsModo), 32'b100);
`endif
    step(12);
    press_to(0);
`ifndef LED_PARPADEO_EN
    check("seq_leds0", 32'(ledsModo), 32'b001);
`endif
    step(12);

    // Plain timeout from mode 2
    press_to(1); step(12);
    press_to(2);
    actividad = 1'b0;
    step(15);
    check("to_15", 32'(modo), 32'd2);
    step(1);
    check("to_16", 32'(modo), 32'd0);
    check("to_16_cambio", 32'(cambioModo), 32'd1);
    actividad = 1'b1;
    step(4);

    // Activity at tick 10 postpones the timeout
    press_to(1); step(12);
    press_to(2);
    actividad = 1'b0;
    step(9);
    actividad = 1'b1;
    step(1);
    actividad = 1'b0;
    step(15);
    check("act_25", 32'(modo), 32'd2);
    step(1);
    check("act_26", 32'(modo), 32'd0);
    actividad = 1'b1;
    step(4);

    // Press on the expiry edge from mode 1: press wins, counter cleared
    press_to(1);
    actividad = 1'b0;
    step(8);
    btnModo = 1'b1;
    step(7);
    check("clash1_15", 32'(modo), 32'd1);
    step(1);
    check("clash1_16", 32'(modo), 32'd2);
    btnModo = 1'b0;
    step(15);
    check("clash1_31", 32'(modo), 32'd2);
    step(1);
    check("clash1_32", 32'(modo), 32'd0);
    actividad = 1'b1;
    step(4);

    // Press on the expiry edge from mode 2: wraps to 0
    press_to(1); step(12);
    press_to(2);
    actividad = 1'b0;
    step(8);
    btnModo = 1'b1;
    step(7);
    check("clash2_15", 32'(modo), 32'd2);
    step(1);
    check("clash2_16", 32'(modo), 32'd0);
    check("clash2_cambio", 32'(cambioModo), 32'd1);
    btnModo = 1'b0;
    actividad = 1'b1;
    step(12);

    // Sparse tick: debounce only advances on tick
    btnModo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick = (i % 3 == 0);
      step(1);
    end
    btnModo = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick = (i % 3 == 0);
      step(1);
    end
    tick = 1'b1;
    check("sparse_modo", 32'(modo), 32'd1);

    // Asynchronous reset mid-count, button held across reset release
    actividad = 1'b0;
    step(5);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_modo", 32'(modo), 32'd0);
    check("arst_leds", 32'(ledsModo), 32'b001);
    check("arst_cambio", 32'(cambioModo), 32'd0);
    btnModo = 1'b1;
    actividad = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    step(7);
    check("held_e7", 32'(modo), 32'd1);
    step(1);
    check("held_once", 32'(modo), 32'd1);
    btnModo = 1'b0;
    step(12);

    // Blink behaviour in mode 1 (steady in the default build)
    press_to(2); step(12);
    press_to(0); step(12);
    press_to(1);
    step(8);
    check("blink_e8", 32'(ledsModo), 32'b010);
    step(1);
`ifdef LED_PARPADEO_EN
    check("blink_e9", 32'(ledsModo), 32'b000);
`else
    check("blink_e9", 32'(ledsModo), 32'b010);
`endif
    step(8);
    check("blink_e17", 32'(ledsModo), 32'b010);
    step(10);
    press_to(2); step(12);
    press_to(0);
    step(30);
    check("mode0_steady", 32'(ledsModo), 32'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
